// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx -- 8N1/8N2 UART transmitter with a valid/ready byte input.
//
// Handshake: a byte moves on a rising CLK edge where valid=1 and ready=1.
// ready is high only while the transmitter is idle; upstream may raise,
// hold or drop valid and change data at any time, and nothing is sampled
// except on the accept edge. busy is always the inverse of ready.
//
// Ports:
//   CLK        system clock, rising-edge active
//   RESET      asynchronous, active-high reset (aborts any frame)
//   data[7:0]  byte to transmit, latched on the accept edge
//   valid      upstream offers data this cycle
//   ready      block can accept a byte this cycle (state == IDLE)
//   busy       frame in progress (== !ready)
//   TXD        serial line, idle high, driven straight from a flop
//   fsm_state  current FSM state (IDLE=0, START=1, DATA=2, STOP=3)
// ---------------------------------------------------------------------------
module uart_tx #(
   parameter int CLKS_PER_BIT = 104,
   parameter int STOP_BITS    = 1
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic [7:0] data,
   input  logic       valid,
   output logic       ready,
   output logic       busy,
   output logic       TXD,
   output logic [1:0] fsm_state
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] baud_q;
   logic [2:0]    idx_q;
   logic [7:0]    shift_q;
   logic          stop_q;
   logic          txd_q, txd_d;

   logic bit_done;
   logic accept;
   logic stop_last;

   assign bit_done  = (baud_q == BAUD_LAST);
   assign accept    = valid && (state_q == IDLE);
   // With one stop bit the first stop period is already the last one.
   assign stop_last = (stop_q == 1'(STOP_BITS - 1));

   // State register plus the datapath registers that travel with it.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= IDLE;
         baud_q  <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         stop_q  <= 1'b0;
         txd_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         txd_q   <= txd_d;
         if (state_q == IDLE) begin
            if (accept) begin
               shift_q <= data;
               baud_q  <= '0;
               idx_q   <= '0;
               stop_q  <= 1'b0;
            end
         end else begin
            baud_q <= bit_done ? '0 : baud_q + CW'(1);
            // The line already shows shift_q[1] on this edge (see txd_d),
            // so the shift and the index move together at the boundary.
            if (state_q == DATA && bit_done) begin
               idx_q   <= idx_q + 3'd1;
               shift_q <= {1'b0, shift_q[7:1]};
            end
            if (state_q == STOP && bit_done) begin
               stop_q <= ~stop_q;
            end
         end
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept)                     state_d = START;
         START:   if (bit_done)                   state_d = DATA;
         DATA:    if (bit_done && idx_q == 3'd7)  state_d = STOP;
         STOP:    if (bit_done && stop_last)      state_d = IDLE;
         default:                                 state_d = IDLE;
      endcase
   end

   // Output logic. TXD is registered, so txd_d is the value the line
   // must carry in the cycle that follows the current edge.
   always_comb begin
      ready = (state_q == IDLE);
      busy  = (state_q != IDLE);
      txd_d = txd_q;
      case (state_q)
         IDLE:    txd_d = ~accept;
         START:   if (bit_done) txd_d = shift_q[0];
         DATA:    if (bit_done) txd_d = (idx_q == 3'd7) ? 1'b1 : shift_q[1];
         STOP:    txd_d = 1'b1;
         default: txd_d = 1'b1;
      endcase
   end

   assign TXD       = txd_q;
   assign fsm_state = state_q;

endmodule

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx -- bench for uart_tx with CLKS_PER_BIT=4. Instance u1 uses one
// stop bit, u2 uses two. Inputs are driven and outputs sampled on the
// falling edge. Bytes are pushed to exp_q when accepted and popped when the
// frame on TXD has been checked and reassembled.
// ---------------------------------------------------------------------------
module tb_uart_tx;

   localparam int CPB = 4;

   // clock / reset
   logic CLK = 1'b0;
   logic RESET = 1'b1;
   always #5 CLK = ~CLK;

   logic [7:0] data = 8'h00;
   logic       valid1 = 1'b0, valid2 = 1'b0;
   logic       ready1, busy1, txd1, ready2, busy2, txd2;
   logic [1:0] st1, st2;

   uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) u1 (
      .CLK(CLK), .RESET(RESET), .data(data), .valid(valid1),
      .ready(ready1), .busy(busy1), .TXD(txd1), .fsm_state(st1));

   uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) u2 (
      .CLK(CLK), .RESET(RESET), .data(data), .valid(valid2),
      .ready(ready2), .busy(busy2), .TXD(txd2), .fsm_state(st2));

   // scoreboard
   logic [7:0] exp_q[$];
   int vectors = 0;
   int miscompares = 0;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic rdy(input bit sel);
      return sel ? ready2 : ready1;
   endfunction
   function automatic logic bsy(input bit sel);
      return sel ? busy2 : busy1;
   endfunction
   function automatic logic txd(input bit sel);
      return sel ? txd2 : txd1;
   endfunction

   task automatic set_valid(input bit sel, input logic v);
      if (sel) valid2 = v;
      else     valid1 = v;
   endtask

   task automatic check_idle(input string tag);
      chk1({tag, "_txd1"}, txd1, 1'b1);
      chk1({tag, "_ready1"}, ready1, 1'b1);
      chk1({tag, "_busy1"}, busy1, 1'b0);
      chk1({tag, "_txd2"}, txd2, 1'b1);
      chk1({tag, "_ready2"}, ready2, 1'b1);
      chk1({tag, "_busy2"}, busy2, 1'b0);
      chk8({tag, "_state1"}, {6'd0, st1}, 8'd0);
   endtask

   // Offer a byte (called on a falling edge); returns on the falling edge of
   // the first cycle after the accept edge.
   task automatic offer(input bit sel, input logic [7:0] b);
      int n;
      data = b;
      set_valid(sel, 1'b1);
      n = 0;
      while (!rdy(sel) && n < 200) begin
         @(negedge CLK);
         n++;
      end
      chk1("accept_wait_ready", rdy(sel), 1'b1);
      exp_q.push_back(b);
      @(negedge CLK);
   endtask

   // Check one full frame cycle by cycle, starting in the first cycle after
   // accept. During the frame data=nd and valid=hv are driven. Ends on the
   // idle cycle; when hv is set, steps past the next accept edge as well.
   task automatic check_frame(input bit sel, input int stop_bits,
                              input logic [7:0] nd, input bit hv);
      logic [7:0] b, rx;
      logic       expbit;
      int         bi;
      b  = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
      rx = 8'h00;
      data = nd;
      set_valid(sel, hv);
      for (int c = 0; c < (9 + stop_bits) * CPB; c++) begin
         bi = c / CPB;
         if (bi == 0)      expbit = 1'b0;
         else if (bi <= 8) expbit = b[bi-1];
         else              expbit = 1'b1;
         chk1("frame_txd", txd(sel), expbit);
         chk1("frame_ready", rdy(sel), 1'b0);
         chk1("frame_busy", bsy(sel), 1'b1);
         if (bi >= 1 && bi <= 8 && (c % CPB) == CPB / 2) rx[bi-1] = txd(sel);
         @(negedge CLK);
      end
      chk8("rx_byte", rx, b);
      chk1("gap_txd", txd(sel), 1'b1);
      chk1("gap_ready", rdy(sel), 1'b1);
      chk1("gap_busy", bsy(sel), 1'b0);
      if (hv) begin
         exp_q.push_back(nd);
         @(negedge CLK);
      end
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      logic [7:0] r;
      // power-on reset, valid low, 3 cycles
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         check_idle("por");
      end
      RESET = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge CLK);
         check_idle("post_por");
      end

      // single byte
      offer(1'b0, 8'hA5);
      check_frame(1'b0, 1, 8'($urandom_range(0, 255)), 1'b0);

      // back-to-back 0x00 then 0xFF, valid held
      offer(1'b0, 8'h00);
      check_frame(1'b0, 1, 8'hFF, 1'b1);
      check_frame(1'b0, 1, 8'h00, 1'b0);

      // data changes while busy
      offer(1'b0, 8'h3C);
      check_frame(1'b0, 1, 8'hFF, 1'b1);
      check_frame(1'b0, 1, 8'h00, 1'b0);

      // reset during data bit 3 of 0x55
      offer(1'b0, 8'h55);
      set_valid(1'b0, 1'b0);
      for (int c = 0; c < 4 * CPB; c++) @(negedge CLK);
      chk1("bit3_txd", txd1, 1'b0);
      #2 RESET = 1'b1;
      #1;
      chk1("async_rst_txd", txd1, 1'b1);
      chk1("async_rst_ready", ready1, 1'b1);
      chk1("async_rst_busy", busy1, 1'b0);
      chk8("async_rst_state", {6'd0, st1}, 8'd0);
      exp_q.delete();
      @(negedge CLK);
      check_idle("rst_hold");
      RESET = 1'b0;
      check_idle("rst_release");
      // accepted on the first edge after release
      offer(1'b0, 8'h81);
      check_frame(1'b0, 1, 8'h00, 1'b0);

      // a few random bytes
      for (int i = 0; i < 3; i++) begin
         r = 8'($urandom_range(0, 255));
         offer(1'b0, r);
         check_frame(1'b0, 1, 8'($urandom_range(0, 255)), 1'b0);
      end

      // two stop bits
      offer(1'b1, 8'h0F);
      check_frame(1'b1, 2, 8'h00, 1'b0);
      @(negedge CLK);
      check_idle("end");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 104, giving CLK cycles per serial bit (12 MHz / 115200 baud); supported range 2..65535.
REQ-002 SHALL have parameter STOP_BITS, default 1, giving the number of stop bits; legal values 1 and 2.
REQ-003 SHALL have port CLK  input  1  system clock; all state changes on rising edge.
REQ-004 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port data  input  8  byte to transmit; sampled only on the accept cycle.
REQ-006 SHALL have port valid  input  1  upstream offers data this cycle.
REQ-007 SHALL have port ready  output  1  block can accept a byte this cycle.
REQ-008 SHALL have port busy  output  1  frame in progress; always equal to !ready.
REQ-009 SHALL have port TXD  output  1  serial line; idle high; registered output.

Function
REQ-010 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-011 SHALL drive ready=1 combinationally iff state==IDLE.
REQ-012 SHALL accept a byte on a rising edge where valid=1 and ready=1: latch data into the shift register, clear the baud counter, enter START.
REQ-013 SHALL perform no transfer when valid=1 and ready=0; upstream holds or withdraws at will.
REQ-014 SHALL drive TXD=0 starting the cycle after accept, for exactly CLKS_PER_BIT cycles (START).
REQ-015 SHALL transmit 8 data bits LSB first in DATA, each held exactly CLKS_PER_BIT cycles.
REQ-016 SHALL track bits with a 3-bit index 0..7 and leave DATA after index 7 completes.
REQ-017 SHALL drive TXD=1 in STOP for exactly STOP_BITS*CLKS_PER_BIT cycles, then enter IDLE.
REQ-018 SHALL make the frame length exactly (9+STOP_BITS)*CLKS_PER_BIT cycles, counted from the cycle after accept.
REQ-019 SHALL keep the baud counter $clog2(CLKS_PER_BIT) bits wide, counting 0..CLKS_PER_BIT-1 and wrapping to 0 at each bit boundary.
REQ-020 SHALL re-enter IDLE on the cycle after the last stop cycle; ready=1 in that cycle.
REQ-021 SHALL, with valid held high, start the next frame after exactly one idle TXD=1 cycle (back-to-back period (9+STOP_BITS)*CLKS_PER_BIT+1).
REQ-022 SHALL ignore changes on data and valid while busy; the latched byte is transmitted unaltered.
REQ-023 SHALL hold TXD=1 continuously in IDLE, with no glitches, since TXD comes straight from a flop.

Reset
REQ-024 SHALL, while RESET=1 and independent of CLK, force state=IDLE, baud counter=0, bit index=0, shift register=0x00, TXD=1.
REQ-025 SHALL, with RESET asserted, hold ready=1 and busy=0.
REQ-026 SHALL abort any frame in progress on a mid-frame reset, with no resumption or retransmission after release.
REQ-027 SHALL accept a byte on the first rising edge after RESET deasserts if valid=1.

Verification (CLKS_PER_BIT=4, STOP_BITS=1 unless stated)
REQ-028 SHALL cover power-on reset: RESET=1 for 3 cycles, valid=0 -> TXD=1, ready=1, busy=0 throughout and after release.
REQ-029 SHALL cover a single byte: send 0xA5 -> TXD = 0 x4, then 1,0,1,0,0,1,0,1 x4 each, then 1 x4; ready=0 for exactly 40 cycles starting the cycle after accept.
REQ-030 SHALL cover back-to-back bytes: 0x00 then 0xFF with valid held -> second start bit falls 41 cycles after the first; exactly one TXD=1 idle cycle between stop and start; the second frame's data bits are all 1.
REQ-031 SHALL cover data changing while busy: accept 0x3C, drive data=0xFF with valid=1 during the frame -> line carries 0x3C; 0xFF is accepted only when ready returns.
REQ-032 SHALL cover reset mid-frame: assert RESET during data bit 3 of 0x55 -> TXD=1 in the same cycle without waiting for CLK; after release, ready=1; sending 0x81 yields a correct complete frame.
REQ-033 SHALL cover STOP_BITS=2: send 0x0F -> stop high for 8 cycles; ready=0 for exactly 44 cycles.
